// File: rtl/enemy_bullet.sv
// enemy_bullet: single enemy projectile. Accepts a launch from the enemy
// formation, drops the bullet one step per frame tick, tests it against the
// player's span and emits a one-cycle hit pulse for the player's hit_i.
// Optional feature macro: ENEMY_BULLET_AUTOFIRE_EN (LFSR-driven self-launch).
module enemy_bullet #(
  parameter int unsigned speed_p      = 4,
  parameter int unsigned spawn_y_p    = 64,
  parameter int unsigned bottom_p     = 479,
  parameter int unsigned player_top_p = 440,
  parameter int unsigned player_bot_p = 470,
  parameter int unsigned bullet_w_p   = 2,
  parameter int unsigned bullet_h_p   = 8,
  parameter int unsigned cooldown_p   = 30
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       freeze_i,
  input  logic       fire_req_i,
  input  logic [9:0] fire_x_i,
  output logic       fire_ack_o,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  output logic       hit_o,
  output logic       bullet_vld_o,
  output logic [9:0] bullet_x_o,
  output logic [9:0] bullet_y_o
);

  localparam int unsigned CntW     = (cooldown_p > 1) ? $clog2(cooldown_p + 1) : 1;
  localparam int unsigned CoolLast = (cooldown_p > 0) ? cooldown_p - 1 : 0;

  localparam logic [9:0]  SpawnY    = 10'(spawn_y_p);
  localparam logic [10:0] Speed     = 11'(speed_p);
  localparam logic [10:0] Bottom    = 11'(bottom_p);
  localparam logic [10:0] PlayerTop = 11'(player_top_p);
  localparam logic [10:0] PlayerBot = 11'(player_bot_p);
  localparam logic [10:0] BulletW   = 11'(bullet_w_p);
  localparam logic [10:0] BulletH   = 11'(bullet_h_p);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    FALL = 4'b0010,
    HIT  = 4'b0100,
    COOL = 4'b1000
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic            vld_q, vld_d;

  logic            launch;
  logic [9:0]      launch_x;
  logic [10:0]     x_end;
  logic [10:0]     y_end;
  logic [10:0]     y_step;
  logic [9:0]      y_sat;
  logic            overlap;

  // External request is only ever acknowledged while idle and not paused.
  assign fire_ack_o = (state_q == IDLE) & fire_req_i & ~freeze_i;

`ifdef ENEMY_BULLET_AUTOFIRE_EN
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] lfsr_mod;

  // Free-running Fibonacci LFSR (taps 10,7) and its folding into 0..599.
  always_comb begin
    lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    lfsr_mod = (lfsr_q >= 10'd600) ? (lfsr_q - 10'd600) : lfsr_q;
  end

  // LFSR register; seeded non-zero so it never locks up.
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= 10'h001;
    else         lfsr_q <= lfsr_d;
  end

  // Idle and running means a shot always goes out; the external column wins.
  assign launch   = (state_q == IDLE) & ~freeze_i;
  assign launch_x = fire_ack_o ? fire_x_i : (lfsr_mod + 10'd8);
`else
  assign launch   = fire_ack_o;
  assign launch_x = fire_x_i;
`endif

  // Inclusive box overlap and saturating fall step, all in 11 bits so nothing wraps.
  always_comb begin
    x_end   = {1'b0, x_q} + BulletW - 11'd1;
    y_end   = {1'b0, y_q} + BulletH - 11'd1;
    overlap = (x_end >= {1'b0, player_left_i}) &&
              ({1'b0, x_q} <= {1'b0, player_right_i}) &&
              (y_end >= PlayerTop) &&
              ({1'b0, y_q} <= PlayerBot);
    y_step  = {1'b0, y_q} + Speed;
    y_sat   = y_step[10] ? 10'h3FF : y_step[9:0];
  end

  // Next-state logic: launch, fall/hit/retire, single-cycle hit, frame cooldown.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          x_d     = launch_x;
          y_d     = SpawnY;
          state_d = FALL;
        end
      end
      FALL: begin
        // Hit takes precedence over the frame move in the same cycle.
        if (!freeze_i) begin
          if (overlap) begin
            state_d = HIT;
          end else if (frame_i) begin
            y_d = y_sat;
            if ({1'b0, y_sat} >= Bottom) begin
              state_d = COOL;
              cnt_d   = '0;
            end
          end
        end
      end
      HIT: begin
        state_d = COOL;
        cnt_d   = '0;
      end
      COOL: begin
        if (cooldown_p == 0) begin
          state_d = IDLE;
        end else if (frame_i && !freeze_i) begin
          if (cnt_q == CntW'(CoolLast)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    hit_d = (state_d == HIT);
    vld_d = (state_d == FALL);
  end

  // State and output registers; reset clears any bullet in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      vld_q   <= vld_d;
    end
  end

  assign hit_o        = hit_q;
  assign bullet_vld_o = vld_q;
  assign bullet_x_o   = x_q;
  assign bullet_y_o   = y_q;

endmodule

// File: tb/tb_enemy_bullet.sv
// Bench for enemy_bullet: ack vector table, overlap-edge vector table and
// hand sequences for hit, retire, freeze, cooldown and mid-flight reset.
module tb_enemy_bullet;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       frame_i;
  logic       freeze_i;
  logic       fire_req_i;
  logic [9:0] fire_x_i;
  logic       fire_ack_o;
  logic [9:0] player_left_i;
  logic [9:0] player_right_i;
  logic       hit_o;
  logic       bullet_vld_o;
  logic [9:0] bullet_x_o;
  logic [9:0] bullet_y_o;

  always #5 clk_i = ~clk_i;

  enemy_bullet dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .frame_i        (frame_i),
    .freeze_i       (freeze_i),
    .fire_req_i     (fire_req_i),
    .fire_x_i       (fire_x_i),
    .fire_ack_o     (fire_ack_o),
    .player_left_i  (player_left_i),
    .player_right_i (player_right_i),
    .hit_o          (hit_o),
    .bullet_vld_o   (bullet_vld_o),
    .bullet_x_o     (bullet_x_o),
    .bullet_y_o     (bullet_y_o)
  );

  typedef struct {
    string      name;
    logic       hit;
    logic       vld;
    logic       chk_xy;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  typedef struct {
    string name;
    logic  req;
    logic  frz;
    logic  ack;
  } ack_vec_t;

  typedef struct {
    string      name;
    logic       frz;
    logic [9:0] left;
    logic [9:0] right;
    logic       hit;
    logic       vld;
  } ovl_vec_t;

  exp_t     exp_q[$];
  ack_vec_t ack_tab[3];
  ovl_vec_t ovl_tab[5];
  int       checks = 0;
  int       errors = 0;
  int       hit_pulses = 0;

  // Count every cycle the hit line is high, independent of the sequences.
  always @(posedge clk_i) begin
    if (hit_o === 1'b1) hit_pulses++;
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input string n, input logic h, input logic v, input logic c,
                          input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.name = n; e.hit = h; e.vld = v; e.chk_xy = c; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = exp_q.pop_front();
    check1({e.name, ".hit"}, hit_o, e.hit);
    check1({e.name, ".vld"}, bullet_vld_o, e.vld);
    if (e.chk_xy) begin
      check1({e.name, ".x"}, bullet_x_o, e.x);
      check1({e.name, ".y"}, bullet_y_o, e.y);
    end
    $display("txn %s hit=%0b vld=%0b x=%0d y=%0d", e.name, hit_o, bullet_vld_o, bullet_x_o, bullet_y_o);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frame_tick();
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    tick();
  endtask

  task automatic ack_probe(input string n, input logic req, input logic frz, input logic exp_ack);
    fire_req_i = req;
    freeze_i   = frz;
    #1;
    check1(n, fire_ack_o, exp_ack);
    fire_req_i = 1'b0;
    freeze_i   = 1'b0;
  endtask

  task automatic fire(input logic [9:0] x);
    fire_x_i   = x;
    fire_req_i = 1'b1;
    #1;
    check1("fire_ack", fire_ack_o, 1);
    tick();
    fire_req_i = 1'b0;
    push_exp("launch", 1'b0, 1'b1, 1'b1, x, 10'd64);
    sample();
  endtask

  // n frames of free fall, starting after k0 frames already taken from spawn.
  task automatic drop(input int n, input int k0, input logic [9:0] x);
    for (int k = 1; k <= n; k++) begin
      frame_tick();
      push_exp("fall", 1'b0, 1'b1, 1'b1, x, 10'(64 + 4 * (k0 + k)));
      sample();
    end
  endtask

  task automatic cool(input int n);
    for (int i = 0; i < n; i++) frame_tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ack_tab[0] = '{"idle_no_req",     1'b0, 1'b0, 1'b0};
    ack_tab[1] = '{"idle_req_frozen", 1'b1, 1'b1, 1'b0};
    ack_tab[2] = '{"idle_frozen_only", 1'b0, 1'b1, 1'b0};

    // Bullet parked at x=326 (right edge 327), y=436 (bottom 443).
    ovl_tab[0] = '{"left_edge_miss", 1'b0, 10'd328, 10'd700, 1'b0, 1'b1};
    ovl_tab[1] = '{"right_edge_miss", 1'b0, 10'd0, 10'd325, 1'b0, 1'b1};
    ovl_tab[2] = '{"frozen_overlap", 1'b1, 10'd300, 10'd326, 1'b0, 1'b1};
    ovl_tab[3] = '{"right_edge_hit", 1'b0, 10'd300, 10'd326, 1'b1, 1'b0};
    ovl_tab[4] = '{"hit_one_cycle", 1'b0, 10'd300, 10'd326, 1'b0, 1'b0};

    reset_i = 1'b1; frame_i = 1'b0; freeze_i = 1'b0; fire_req_i = 1'b0;
    fire_x_i = '0; player_left_i = 10'd600; player_right_i = 10'd700;
    tick();
    tick();
    push_exp("reset", 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    sample();
    check1("reset_ack", fire_ack_o, 0);
    reset_i = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) ack_probe(ack_tab[i].name, ack_tab[i].req, ack_tab[i].frz, ack_tab[i].ack);

    // Launch at 300, then requests during flight are ignored.
    fire(10'd300);
    ack_probe("ack_in_fall", 1'b1, 1'b0, 1'b0);

    // Fall to y=200, pause 10 frames, resume, then fall into the player.
    player_left_i = 10'd290; player_right_i = 10'd325;
    drop(34, 0, 10'd300);
    freeze_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame_tick();
      push_exp("frozen", 1'b0, 1'b1, 1'b1, 10'd300, 10'd200);
      sample();
    end
    freeze_i = 1'b0;
    drop(1, 34, 10'd300);
    drop(57, 35, 10'd300);
    check1("no_hit_before_436", hit_pulses, 0);
    frame_tick();
    push_exp("hit", 1'b1, 1'b0, 1'b1, 10'd300, 10'd436);
    sample();
    tick();
    push_exp("hit_end", 1'b0, 1'b0, 1'b1, 10'd300, 10'd436);
    sample();
    check1("hit_pulse_count", hit_pulses, 1);

    // Cooldown: frozen frames do not count; 29 real frames is not enough.
    ack_probe("ack_in_cool", 1'b1, 1'b0, 1'b0);
    cool(10);
    freeze_i = 1'b1;
    cool(5);
    freeze_i = 1'b0;
    cool(19);
    ack_probe("ack_cool_29", 1'b1, 1'b0, 1'b0);
    cool(1);

    // Miss: player far left, bullet retires at y=480 after 104 frames.
    player_left_i = 10'd8; player_right_i = 10'd43;
    fire(10'd300);
    drop(103, 0, 10'd300);
    frame_i = 1'b1;
    tick();
    push_exp("retire", 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    sample();
    frame_i = 1'b0;
    tick();
    check1("no_hit_on_miss", hit_pulses, 1);
    cool(30);

    // Edge overlap vectors on a bullet parked at y=436.
    player_left_i = 10'd600; player_right_i = 10'd700;
    fire(10'd326);
    drop(93, 0, 10'd326);
    for (int i = 0; i < 5; i++) begin
      freeze_i       = ovl_tab[i].frz;
      player_left_i  = ovl_tab[i].left;
      player_right_i = ovl_tab[i].right;
      push_exp(ovl_tab[i].name, ovl_tab[i].hit, ovl_tab[i].vld, 1'b1, 10'd326, 10'd436);
      tick();
      sample();
      freeze_i = 1'b0;
    end
    check1("edge_hit_count", hit_pulses, 2);
    cool(30);

    // One column further right never touches a player ending at 326.
    player_left_i = 10'd300; player_right_i = 10'd326;
    fire(10'd327);
    drop(93, 0, 10'd327);
    tick();
    tick();
    check1("edge_miss_327", hit_pulses, 2);

    // Reset in flight removes the bullet with no hit and returns to idle.
    reset_i = 1'b1;
    tick();
    push_exp("reset_mid", 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    sample();
    reset_i = 1'b0;
    ack_probe("ack_after_reset", 1'b1, 1'b0, 1'b1);
    check1("reset_no_hit", hit_pulses, 2);
    check1("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
